// File: rtl/fp_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_queue
// Purpose  : Result buffer between the FPU result register and the shared
//            register-file writeback port, with per-slot kill and issue stall.
// Revision : 1.0 - initial release
// ============================================================================
module fp_wb_queue #(
    parameter int RV           = 64,
    parameter int NHART        = 1,
    parameter int NCOMMIT      = 32,
    parameter int LNCOMMIT     = 5,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NHART-1:0]    in_makes_rd,
    input  logic [RV-1:0]       in_result,
    input  logic [LNCOMMIT-1:0] in_rd,
    input  logic                in_fp,
    input  logic [4:0]          in_flags,
    input  logic [NCOMMIT-1:0]  commit_kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RV-1:0]       out_result,
    output logic [LNCOMMIT-1:0] out_rd,
    output logic                out_fp,
    output logic [NHART-1:0]    out_makes_rd,
    output logic [4:0]          out_flags,
    output logic                stall,
    output logic                overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_STALL_AT = c_CW'(DEPTH - STALL_MARGIN);

    logic                r_live   [DEPTH];
    logic [RV-1:0]       r_result [DEPTH];
    logic [LNCOMMIT-1:0] r_rd     [DEPTH];
    logic                r_fp     [DEPTH];
    logic [NHART-1:0]    r_hart   [DEPTH];
    logic [4:0]          r_flags  [DEPTH];

    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            r_stall;
    logic            r_overflow;

    logic            w_push_req;
    logic            w_nonempty;
    logic            w_head_killed;
    logic            w_hole;
    logic            w_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [c_CW-1:0] w_count_nxt;

    assign w_push_req    = (|in_makes_rd) && !commit_kill[in_rd];
    assign w_nonempty    = (r_count != '0);
    assign w_head_killed = commit_kill[r_rd[r_head]];
    assign w_valid       = w_nonempty && r_live[r_head] && !w_head_killed;
    // Holes (killed entries) drain one per cycle without waiting for a grant.
    assign w_hole        = w_nonempty && (!r_live[r_head] || w_head_killed);
    assign w_pop         = (w_valid && out_ready) || w_hole;
    assign w_full        = (r_count == c_FULL);
    assign w_push        = w_push_req && (!w_full || w_pop);
    assign w_drop        = w_push_req && w_full && !w_pop;
    assign w_count_nxt   = r_count + c_CW'(w_push) - c_CW'(w_pop);

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            // A fresh push overrides a kill aimed at the stale slot contents.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_live[g] <= 1'b0;
                end else if (w_push && (r_tail == c_AW'(g))) begin
                    r_live[g] <= 1'b1;
                end else if (commit_kill[r_rd[g]]) begin
                    r_live[g] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push && (r_tail == c_AW'(g))) begin
                    r_result[g] <= in_result;
                    r_rd[g]     <= in_rd;
                    r_fp[g]     <= in_fp;
                    r_hart[g]   <= in_makes_rd;
                    r_flags[g]  <= in_flags;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + c_AW'(1);
            if (w_pop)  r_head <= r_head + c_AW'(1);
            r_count    <= w_count_nxt;
            r_stall    <= (w_count_nxt >= c_STALL_AT);
            r_overflow <= r_overflow || w_drop;
        end
    end

    assign out_valid    = w_valid;
    assign out_result   = r_result[r_head];
    assign out_rd       = r_rd[r_head];
    assign out_fp       = r_fp[r_head];
    assign out_flags    = r_flags[r_head];
    assign out_makes_rd = w_valid ? r_hart[r_head] : '0;
    assign stall        = r_stall;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_wb_queue
// Purpose  : Scoreboard bench for fp_wb_queue (ordering, kills, full, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_wb_queue;

    logic        clk;
    logic        reset;
    logic [0:0]  in_makes_rd;
    logic [63:0] in_result;
    logic [4:0]  in_rd;
    logic        in_fp;
    logic [4:0]  in_flags;
    logic [31:0] commit_kill;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_fp;
    logic [0:0]  out_makes_rd;
    logic [4:0]  out_flags;
    logic        stall;
    logic        overflow;

    fp_wb_queue dut (
        .clk          (clk),
        .reset        (reset),
        .in_makes_rd  (in_makes_rd),
        .in_result    (in_result),
        .in_rd        (in_rd),
        .in_fp        (in_fp),
        .in_flags     (in_flags),
        .commit_kill  (commit_kill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_fp       (out_fp),
        .out_makes_rd (out_makes_rd),
        .out_flags    (out_flags),
        .stall        (stall),
        .overflow     (overflow)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        fp;
        logic [0:0]  hart;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every grant must match the oldest surviving expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", {59'd0, out_rd}, 64'hffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_rd", {59'd0, out_rd}, {59'd0, e.rd});
                check("wb_result", out_result, e.res);
                check("wb_fp_hart_flags", {57'd0, out_fp, out_makes_rd, out_flags},
                      {57'd0, e.fp, e.hart, e.fl});
            end
        end
    end

    function automatic logic [63:0] val_of(input logic [4:0] rd);
        return 64'h4000_0000_0000_0000 | {59'd0, rd};
    endfunction

    // Drive one cycle of inputs just after the edge and update the model.
    task automatic drive(input logic mk, input logic [63:0] val, input logic [4:0] rd,
                         input logic fp, input logic [31:0] kill, input logic rdy,
                         input logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_makes_rd = mk;
        in_result   = val;
        in_rd       = rd;
        in_fp       = fp;
        in_flags    = rd ^ 5'h15;
        commit_kill = kill;
        out_ready   = rdy;
        for (int b = 0; b < 32; b++) begin
            if (kill[b]) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].rd == 5'(b)) sb.delete(i);
            end
        end
        if (mk && !kill[rd] && acc) begin
            e.res = val; e.rd = rd; e.fp = fp; e.hart = 1'b1; e.fl = rd ^ 5'h15;
            sb.push_back(e);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic rdy);
        drive(1'b1, val_of(rd), rd, rd[0], 32'd0, rdy, 1'b1);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 64'd0, 5'd0, 1'b0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        in_makes_rd = '0; in_result = '0; in_rd = '0; in_fp = 1'b0;
        in_flags = '0; commit_kill = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_hart", {63'd0, out_makes_rd}, 64'd0);
        check("reset_stall_ovf", {62'd0, stall, overflow}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single pass-through, no bypass.
        drive(1'b1, 64'h3ff0_0000_0000_0000, 5'd5, 1'b1, 32'd0, 1'b1, 1'b1);
        @(negedge clk) check("pt_no_bypass", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        @(negedge clk) check("pt_valid", {63'd0, out_valid}, 64'd1);
        idle(1'b1);
        @(negedge clk) check("pt_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure, stall threshold and ordering.
        push(5'd1, 1'b0);
        push(5'd2, 1'b0);
        @(negedge clk) check("bp_stall_before", {63'd0, stall}, 64'd0);
        push(5'd3, 1'b0);
        @(negedge clk) check("bp_stall_set", {63'd0, stall}, 64'd1);
        idle(1'b1);
        @(negedge clk) check("bp_out1", {59'd0, out_rd}, 64'd1);
        idle(1'b1);
        @(negedge clk) check("bp_out2", {59'd0, out_rd}, 64'd2);
        idle(1'b1);
        @(negedge clk) begin
            check("bp_out3", {59'd0, out_rd}, 64'd3);
            check("bp_stall_clear", {63'd0, stall}, 64'd0);
        end
        idle(1'b1);
        @(negedge clk) check("bp_empty", {63'd0, out_valid}, 64'd0);

        // Kill while waiting leaves a hole that costs one cycle.
        push(5'd7, 1'b0);
        push(5'd8, 1'b0);
        push(5'd9, 1'b0);
        drive(1'b0, 64'd0, 5'd0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        idle(1'b1);
        @(negedge clk) check("kw_out7", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'd7});
        idle(1'b1);
        @(negedge clk) check("kw_hole", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        @(negedge clk) check("kw_out9", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'd9});
        idle(1'b1);
        @(negedge clk) check("kw_empty", {63'd0, out_valid}, 64'd0);

        // Kill on arrival, then kill at head.
        drive(1'b1, val_of(5'd4), 5'd4, 1'b0, 32'h0000_0010, 1'b1, 1'b1);
        idle(1'b1);
        @(negedge clk) check("ka_dropped", {63'd0, out_valid}, 64'd0);
        push(5'd6, 1'b0);
        drive(1'b0, 64'd0, 5'd0, 1'b0, 32'h0000_0040, 1'b1, 1'b0);
        @(negedge clk) check("kh_suppressed", {62'd0, out_valid, out_makes_rd}, 64'd0);
        idle(1'b1);
        @(negedge clk) check("kh_gone", {63'd0, out_valid}, 64'd0);

        // Full: push with pop accepted, push without pop dropped.
        for (int i = 0; i < 4; i++) push(5'(10 + i), 1'b0);
        idle(1'b0);
        @(negedge clk) check("full_stall_ovf", {62'd0, stall, overflow}, 64'd2);
        push(5'd14, 1'b1);
        @(negedge clk) check("full_swap_rd", {59'd0, out_rd}, 64'd10);
        drive(1'b1, val_of(5'd15), 5'd15, 1'b1, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk) check("full_overflow", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            @(negedge clk) check("full_drain", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'(11 + i)});
        end
        idle(1'b1);
        @(negedge clk) begin
            check("full_drained", {63'd0, out_valid}, 64'd0);
            check("ovf_sticky", {63'd0, overflow}, 64'd1);
        end

        // Reset mid-drain discards contents and clears status.
        push(5'd20, 1'b0);
        push(5'd21, 1'b0);
        push(5'd22, 1'b0);
        idle(1'b0);
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        idle(1'b1);
        reset = 1'b0;
        @(negedge clk) check("rst_mid", {61'd0, out_valid, stall, overflow}, 64'd0);
        push(5'd23, 1'b1);
        @(negedge clk) check("rst_push_nobypass", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        @(negedge clk) check("rst_push_out", {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'd23});
        idle(1'b1);
        @(negedge clk) check("rst_push_empty", {63'd0, out_valid}, 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
